// File: rtl/systolic_pkg.sv
// Constants, FSM encoding and helpers shared by the systolic feeder and the MAC array.
package systolic_pkg;

  localparam int unsigned PE_ROW_DEFAULT           = 16;
  localparam int unsigned PE_COL_DEFAULT           = 16;
  localparam int unsigned INPUT_DATA_WIDTH_DEFAULT = 8;
  localparam int unsigned DRAIN_CYCLES_DEFAULT     = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFeed  = 2'd1,
    StFlush = 2'd2,
    StSave  = 2'd3
  } feeder_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth registered shift line carrying one data word plus its valid flag.
module skew_delay_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) data_q[i] <= '0;
      valid_q <= '0;
    end else begin
      data_q[0]  <= in_data;
      valid_q[0] <= in_valid;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        data_q[i]  <= data_q[i-1];
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  assign out_data  = data_q[DEPTH-1];
  assign out_valid = valid_q[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Skews activation vectors onto the systolic array rows and pulses save once a tile has drained.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned PE_ROW           = PE_ROW_DEFAULT,
  parameter int unsigned INPUT_DATA_WIDTH = INPUT_DATA_WIDTH_DEFAULT,
  parameter int unsigned DRAIN_CYCLES     = DRAIN_CYCLES_DEFAULT
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [INPUT_DATA_WIDTH*PE_ROW-1:0] in_data,
  input  logic                               in_valid,
  input  logic                               in_last,
  output logic                               in_ready,
  output logic [INPUT_DATA_WIDTH*PE_ROW-1:0] out_a_bus,
  output logic [PE_ROW-1:0]                  enable,
  output logic                               save,
  output logic                               busy
);

  localparam int unsigned W       = INPUT_DATA_WIDTH;
  localparam int unsigned CntBits = clog2(PE_ROW + DRAIN_CYCLES);
  localparam int unsigned CntW    = (CntBits > 0) ? CntBits : 1;
  // Assumes PE_ROW + DRAIN_CYCLES >= 2 so the flush count is never zero.
  localparam logic [CntW-1:0] FlushLoad = CntW'(PE_ROW - 1 + DRAIN_CYCLES);

  feeder_state_e   state_q;
  logic [CntW-1:0] cnt_q;
  logic            in_ready_q;
  logic            busy_q;
  logic            save_q;
  logic            transfer;

  assign transfer = in_valid && in_ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      save_q     <= 1'b0;
    end else begin
      save_q <= 1'b0;
      unique case (state_q)
        StIdle, StFeed: begin
          if (transfer && in_last) begin
            state_q    <= StFlush;
            cnt_q      <= FlushLoad;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end else if (transfer) begin
            state_q    <= StFeed;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end else begin
            in_ready_q <= 1'b1;
            busy_q     <= (state_q == StFeed);
          end
        end
        StFlush: begin
          cnt_q <= cnt_q - CntW'(1);
          // Leaving on the decrement to zero lands save on the last-accept + PE_ROW + DRAIN cycle.
          if (cnt_q == CntW'(1)) begin
            state_q <= StSave;
            save_q  <= 1'b1;
          end
        end
        StSave: begin
          state_q    <= StIdle;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign save     = save_q;

  for (genvar r = 0; r < PE_ROW; r++) begin : g_row
    logic [W-1:0] row_in;
    logic [W-1:0] row_out;
    logic         row_valid;

    // Gating at the input keeps bubble rows at zero all the way down the line.
    assign row_in = transfer ? in_data[r*W +: W] : '0;

    skew_delay_line #(
      .DEPTH(r + 1),
      .WIDTH(W)
    ) u_line (
      .clk      (clk),
      .clr      (rst),
      .in_data  (row_in),
      .in_valid (transfer),
      .out_data (row_out),
      .out_valid(row_valid)
    );

    assign out_a_bus[r*W +: W] = row_out;
    assign enable[r]           = row_valid;
  end

endmodule
